// File: rtl/leaf_router_pkg.sv
// rtl/leaf_router_pkg.sv - shared constants and types for the leaf router schedulers
//
// Purpose: requester indices, direction codes, idle grant marker, scheduler
// state encoding, destination field positions and a round-robin helper.
// Ports: none (package).

package leaf_router_pkg;

  // Requester / port indices
  localparam logic [2:0] REQ_GPU = 3'd0;
  localparam logic [2:0] REQ_SP1 = 3'd1;
  localparam logic [2:0] REQ_SP2 = 3'd2;
  localparam logic [2:0] REQ_SP3 = 3'd3;
  localparam logic [2:0] REQ_SP4 = 3'd4;

  localparam int NUM_REQ = 5;

  // Crossbar direction status
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_DROP = 2'b11;

  // current_grant value while nothing is granted
  localparam logic [2:0] IDLE_GRANT = 3'd7;

  // Destination field positions inside a 6-bit destination
  localparam int GRP_MSB = 5;
  localparam int GRP_LSB = 2;
  localparam int RTR_MSB = 1;
  localparam int RTR_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2
  } sched_state_t;

  // Index following i in the 0..4 ring
  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i >= 3'd4) ? 3'd0 : i + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// rtl/rr_pick5.sv - combinational five-way round-robin picker
//
// Purpose: returns the first asserted request at or after ptr, wrapping
// modulo 5. Shared by the leaf and spine-side schedulers.
// Ports:
//   req   in  5  request vector
//   ptr   in  3  starting index (0-4)
//   valid out 1  at least one request present
//   index out 3  chosen requester index

module rr_pick5 (
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic       valid,
  output logic [2:0] index
);

  logic [3:0] sum;
  logic [2:0] cand;

  // Walk the ring from the farthest offset down to offset 0 so that the
  // closest requester to ptr is the last (and therefore winning) assignment.
  always_comb begin
    valid = 1'b0;
    index = 3'd0;
    sum   = 4'd0;
    cand  = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      sum = {1'b0, ptr} + 4'(k);
      if (sum >= 4'd5) sum = sum - 4'd5;
      cand = sum[2:0];
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/leaf_xbar_scheduler.sv
// rtl/leaf_xbar_scheduler.sv - round-robin burst scheduler for the leaf crossbar
//
// Purpose: shares the leaf crossbar between the GPU and spines 1-4. Decodes the
// winner's destination, holds the grant for up to MAX_BURST beats, then
// rotates. Non-routable requests are acknowledged for one cycle and counted.
// Ports:
//   clk           in  1   system clock
//   reset         in  1   synchronous active-high reset
//   arb_enable    in  1   permits grants; low releases an active grant
//   req           in  5   requests, bit0=GPU, bit1..4=spine1..4
//   dest_addr     in  30  6-bit destination per requester
//   tgt_ready     in  5   target port can accept a beat
//   grant         out 5   one-hot registered grant
//   beat          out 1   a beat moves this cycle
//   target_sel    out 3   target port index
//   current_grant out 3   granted requester, 7 when idle
//   direction     out 2   idle / up / down / drop
//   busy          out 1   transfer or drop in progress
//   drop_count    out 8   saturating dropped-request count

module leaf_xbar_scheduler
  import leaf_router_pkg::*;
#(
  parameter logic [1:0] ROUTER_ID = 2'd2,
  parameter logic [3:0] GROUP_ID  = 4'b0111,
  parameter int         MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arb_enable,
  input  logic [4:0]  req,
  input  logic [29:0] dest_addr,
  input  logic [4:0]  tgt_ready,
  output logic [4:0]  grant,
  output logic        beat,
  output logic [2:0]  target_sel,
  output logic [2:0]  current_grant,
  output logic [1:0]  direction,
  output logic        busy,
  output logic [7:0]  drop_count
);

  sched_state_t state;
  logic [2:0]   rr_ptr;
  logic [3:0]   beat_cnt;

  logic         pick_valid;
  logic [2:0]   pick_idx;
  logic [5:0]   pick_dest;
  logic         is_local;
  logic         dec_drop;
  logic [1:0]   dec_dir;
  logic [2:0]   dec_target;
  logic         last_beat;
  logic         xfer_release;

  rr_pick5 u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Destination decode for the round-robin winner
  always_comb begin
    case (pick_idx)
      3'd1:    pick_dest = dest_addr[11:6];
      3'd2:    pick_dest = dest_addr[17:12];
      3'd3:    pick_dest = dest_addr[23:18];
      3'd4:    pick_dest = dest_addr[29:24];
      default: pick_dest = dest_addr[5:0];
    endcase

    is_local = (pick_dest[GRP_MSB:GRP_LSB] == GROUP_ID) &&
               (pick_dest[RTR_MSB:RTR_LSB] == ROUTER_ID);

    if (pick_idx == REQ_GPU) begin
      // GPU traffic leaves upward; a destination of this very leaf is a loopback
      dec_drop   = is_local;
      dec_dir    = DIR_UP;
      dec_target = {1'b0, pick_dest[RTR_MSB:RTR_LSB]} + 3'd1;
    end else begin
      // Spine traffic is only accepted when it is addressed to this leaf
      dec_drop   = !is_local;
      dec_dir    = DIR_DOWN;
      dec_target = REQ_GPU;
    end
  end

  // Beat is combinational from the registered grant so the target sees it in
  // the same cycle its ready is high.
  assign beat         = (state == ST_XFER) && tgt_ready[target_sel];
  assign last_beat    = beat && (beat_cnt == 4'(MAX_BURST - 1));
  assign xfer_release = !req[current_grant] || !arb_enable || last_beat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      rr_ptr        <= 3'd0;
      beat_cnt      <= 4'd0;
      grant         <= 5'd0;
      target_sel    <= 3'd0;
      current_grant <= IDLE_GRANT;
      direction     <= DIR_IDLE;
      busy          <= 1'b0;
      drop_count    <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_enable && pick_valid) begin
            grant         <= 5'b00001 << pick_idx;
            current_grant <= pick_idx;
            busy          <= 1'b1;
            beat_cnt      <= 4'd0;
            if (dec_drop) begin
              state      <= ST_DROP;
              direction  <= DIR_DROP;
              target_sel <= 3'd0;
            end else begin
              state      <= ST_XFER;
              direction  <= dec_dir;
              target_sel <= dec_target;
            end
          end
        end

        ST_XFER: begin
          if (xfer_release) begin
            state         <= ST_IDLE;
            rr_ptr        <= next_idx(current_grant);
            beat_cnt      <= 4'd0;
            grant         <= 5'd0;
            target_sel    <= 3'd0;
            current_grant <= IDLE_GRANT;
            direction     <= DIR_IDLE;
            busy          <= 1'b0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 4'd1;
          end
        end

        ST_DROP: begin
          // One-cycle acknowledge; the count sticks at its maximum
          if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
          state         <= ST_IDLE;
          rr_ptr        <= next_idx(current_grant);
          beat_cnt      <= 4'd0;
          grant         <= 5'd0;
          target_sel    <= 3'd0;
          current_grant <= IDLE_GRANT;
          direction     <= DIR_IDLE;
          busy          <= 1'b0;
        end

        default: begin
          state         <= ST_IDLE;
          grant         <= 5'd0;
          current_grant <= IDLE_GRANT;
          direction     <= DIR_IDLE;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_xbar_scheduler.sv
// tb/tb_leaf_xbar_scheduler.sv - self-checking bench for leaf_xbar_scheduler

module tb_leaf_xbar_scheduler;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        arb_enable;
  logic [4:0]  req;
  logic [29:0] dest_addr;
  logic [4:0]  tgt_ready;
  logic [4:0]  grant;
  logic        beat;
  logic [2:0]  target_sel;
  logic [2:0]  current_grant;
  logic [1:0]  direction;
  logic        busy;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  leaf_xbar_scheduler #(
    .ROUTER_ID (2'd2),
    .GROUP_ID  (4'b0111),
    .MAX_BURST (MAXB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .arb_enable    (arb_enable),
    .req           (req),
    .dest_addr     (dest_addr),
    .tgt_ready     (tgt_ready),
    .grant         (grant),
    .beat          (beat),
    .target_sel    (target_sel),
    .current_grant (current_grant),
    .direction     (direction),
    .busy          (busy),
    .drop_count    (drop_count)
  );

  int n_vec = 0;
  int n_bad = 0;
  int beats_seen = 0;

  // Values sampled at the last falling edge
  logic [4:0] s_grant;
  logic       s_beat;
  logic [2:0] s_ts;
  logic [2:0] s_cg;
  logic [1:0] s_dir;
  logic       s_busy;
  logic [7:0] s_drops;

  // Reference model: 0 idle, 1 transferring, 2 dropping
  int m_mode, m_owner, m_ptr, m_cnt, m_drops, m_tgt, m_dir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_drops = 0; m_tgt = 0; m_dir = 0;
  endtask

  task automatic model_step();
    int pick, d, rtr, grp;
    logic [29:0] sh;
    bit loc, drop, b;
    if (reset) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: if (arb_enable && req != 5'd0) begin
        pick = -1;
        for (int k = 0; k < 5; k++)
          if (pick < 0 && req[(m_ptr + k) % 5]) pick = (m_ptr + k) % 5;
        sh  = dest_addr >> (6 * pick);
        d   = int'(sh[5:0]);
        grp = d / 4;
        rtr = d % 4;
        loc = (grp == 7) && (rtr == 2);
        drop = (pick == 0) ? loc : !loc;
        m_owner = pick;
        m_cnt = 0;
        if (drop) begin
          m_mode = 2; m_tgt = 0; m_dir = 3;
        end else begin
          m_mode = 1;
          m_tgt = (pick == 0) ? rtr + 1 : 0;
          m_dir = (pick == 0) ? 1 : 2;
        end
      end
      1: begin
        b = tgt_ready[m_tgt];
        if (!req[m_owner] || !arb_enable || (b && m_cnt == MAXB - 1)) begin
          m_mode = 0; m_ptr = (m_owner + 1) % 5; m_cnt = 0;
        end else if (b) begin
          m_cnt++;
        end
      end
      default: begin
        if (m_drops < 255) m_drops++;
        m_mode = 0; m_ptr = (m_owner + 1) % 5;
      end
    endcase
  endtask

  function automatic logic [22:0] model_out();
    logic [4:0] g;
    logic       bt;
    logic [2:0] ts, cg;
    logic [1:0] dr;
    g  = (m_mode != 0) ? (5'b00001 << m_owner) : 5'd0;
    bt = (m_mode == 1) && tgt_ready[m_tgt];
    ts = (m_mode == 1) ? 3'(m_tgt) : 3'd0;
    cg = (m_mode != 0) ? 3'(m_owner) : 3'd7;
    dr = (m_mode != 0) ? 2'(m_dir) : 2'd0;
    return {g, bt, ts, cg, dr, (m_mode != 0), 8'(m_drops)};
  endfunction

  // One clock: sample at the falling edge, optionally check against the
  // model, advance the model with the inputs seen by the rising edge.
  task automatic tick(input bit use_model);
    @(negedge clk);
    s_grant = grant; s_beat = beat; s_ts = target_sel; s_cg = current_grant;
    s_dir = direction; s_busy = busy; s_drops = drop_count;
    if (s_beat === 1'b1) beats_seen++;
    if (use_model)
      chk("model", {9'd0, s_grant, s_beat, s_ts, s_cg, s_dir, s_busy, s_drops},
          {9'd0, model_out()});
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    req = 5'd0; reset = 1'b0; arb_enable = 1'b1; tgt_ready = 5'h1F;
    repeat (3) tick(1);
  endtask

  typedef struct {
    logic       rst;
    logic       arb;
    logic [4:0] rq;
    logic [4:0] tr;
    logic [4:0] g;
    logic [2:0] ts;
    logic [2:0] cg;
    logic [1:0] dr;
    logic       bsy;
    logic       bt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // rst arb req tr | grant ts cg dir busy beat (sampled before this row's edge)
    tbl[0] = '{1'b1, 1'b1, 5'h00, 5'h1F, 5'h00, 3'd0, 3'd7, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 5'h01, 5'h1F, 5'h00, 3'd0, 3'd7, 2'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 5'h01, 5'h1F, 5'h01, 3'd2, 3'd0, 2'd1, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 5'h01, 5'h1F, 5'h01, 3'd2, 3'd0, 2'd1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 5'h01, 5'h1F, 5'h01, 3'd2, 3'd0, 2'd1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 5'h01, 5'h1F, 5'h01, 3'd2, 3'd0, 2'd1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 5'h01, 5'h1F, 5'h00, 3'd0, 3'd7, 2'd0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 5'h00, 5'h1F, 5'h01, 3'd2, 3'd0, 2'd1, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 5'h00, 5'h1F, 5'h00, 3'd0, 3'd7, 2'd0, 1'b0, 1'b0};

    reset = 1'b1; arb_enable = 1'b0; req = 5'd0; tgt_ready = 5'h1F;
    dest_addr = {24'd0, 6'b011101};
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Burst of four to spine2, release, bubble, regrant
    for (int i = 0; i < 9; i++) begin
      reset = tbl[i].rst; arb_enable = tbl[i].arb; req = tbl[i].rq; tgt_ready = tbl[i].tr;
      tick(0);
      chk($sformatf("tbl[%0d]", i), {17'd0, s_grant, s_ts, s_cg, s_dir, s_busy, s_beat},
          {17'd0, tbl[i].g, tbl[i].ts, tbl[i].cg, tbl[i].dr, tbl[i].bsy, tbl[i].bt});
    end
    chk("tbl_drops", {24'd0, s_drops}, 32'd0);

    // Three local spine requests rotate 1,2,4 from pointer 0
    reset = 1'b1; tick(1); reset = 1'b0;
    dest_addr = {4{6'b011110}} << 6 | 30'(6'b011101);
    req = 5'b10110;
    repeat (20) tick(1);
    go_idle();

    // Spine3 to a foreign leaf: one-cycle drop, pointer moves to 4
    begin
      logic [7:0] d0;
      dest_addr = {6'b011110, 6'b010010, 18'd0};
      req = 5'b01000;
      tick(1);
      d0 = s_drops;
      req = 5'b00000;
      tick(1);
      chk("drop_grant", {27'd0, s_grant}, 32'h08);
      chk("drop_dir", {30'd0, s_dir}, 32'd3);
      chk("drop_beat", {31'd0, s_beat}, 32'd0);
      req = 5'b11111;
      tick(1);
      chk("drop_count_inc", {24'd0, s_drops}, {24'd0, d0 + 8'd1});
      tick(1);
      chk("drop_rr_ptr", {29'd0, s_cg}, 32'd4);
      go_idle();
    end

    // Stalled target holds the grant without beats
    dest_addr = {24'd0, 6'b011101};
    req = 5'b00001; tgt_ready = 5'b11011;
    beats_seen = 0;
    repeat (11) tick(1);
    chk("stall_grant", {27'd0, s_grant}, 32'h01);
    chk("stall_beats", beats_seen, 0);
    tgt_ready = 5'h1F;
    repeat (4) tick(1);
    chk("stall_burst", beats_seen, 4);
    req = 5'd0;
    tick(1);
    chk("stall_release", {31'd0, s_busy}, 32'd0);
    go_idle();

    // arb_enable low mid-transfer releases and blocks new grants
    req = 5'b00001;
    repeat (2) tick(1);
    arb_enable = 1'b0;
    tick(1);
    repeat (3) begin
      tick(1);
      chk("arb_off_grant", {27'd0, s_grant}, 32'd0);
    end
    go_idle();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 5; r++) begin
        logic [5:0] d;
        d = 6'($urandom);
        if ($urandom_range(0, 1) == 0) d[5:2] = 4'b0111;
        dest_addr[6*r +: 6] = d;
      end
      req        = 5'($urandom);
      tgt_ready  = 5'($urandom);
      arb_enable = ($urandom_range(0, 9) != 0);
      reset      = ($urandom_range(0, 63) == 0);
      tick(1);
    end
    go_idle();

    // 300 back-to-back drops saturate the counter
    dest_addr = 30'd0;
    req = 5'b00010;
    repeat (600) tick(1);
    req = 5'd0;
    tick(1);
    chk("drop_saturate", {24'd0, s_drops}, 32'd255);

    // Reset in the middle of a burst
    dest_addr = {24'd0, 6'b011101};
    req = 5'b00001;
    repeat (3) tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0; req = 5'd0;
    tick(1);
    chk("rst_mid_out", {9'd0, s_grant, s_beat, s_ts, s_cg, s_dir, s_busy, s_drops},
        {9'd0, 5'd0, 1'b0, 3'd0, 3'd7, 2'd0, 1'b0, 8'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/leaf_xbar_scheduler.md
Name: leaf_xbar_scheduler

Overview:
- Round-robin scheduler for the leaf router's bidirectional crossbar. It shares the crossbar between five requesters: the GPU and spines 1-4.
- Decodes each requester's 6-bit destination and picks the target port. Holds the grant for a burst, then rotates. Drives the crossbar's busy/current_grant/direction status.
- Sits beside the crossbar inside the leaf router and replaces the tied-off readies with real per-port flow control.

Parameters:
- ROUTER_ID, 2, this leaf's router index; compared with dest_addr[1:0].
- GROUP_ID, 4'b0111, this leaf's group; compared with dest_addr[5:2].
- MAX_BURST, 4, maximum beats per grant before a forced rotation; legal range 1-15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- arb_enable  in  1  permits new grants; when low, an active grant releases at the next edge
- req  in  5  request per requester; bit0=GPU, bit1..4=spine1..4
- dest_addr  in  30  flattened destinations; bits [6i+5:6i] belong to requester i
- tgt_ready  in  5  target can accept a beat; bit0=GPU out, bit1..4=spine1..4 out
- grant  out  5  one-hot grant, registered
- beat  out  1  a beat transfers this cycle (grant valid && tgt_ready[target])
- target_sel  out  3  target port index 0-4
- current_grant  out  3  granted requester index 0-4; 3'd7 when idle
- direction  out  2  00 idle, 01 up (GPU->spine), 10 down (spine->GPU), 11 drop
- busy  out  1  high in XFER or DROP
- drop_count  out  8  saturating count of dropped requests

Behaviour:
- Clock and reset: single clock domain, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, rr_ptr=0, grant=0, beat=0, target_sel=0, current_grant=7, direction=00, busy=0, drop_count=0, beat_cnt=0.
- Destination decode for requester i:
  - local = (dest[5:2]==GROUP_ID && dest[1:0]==ROUTER_ID).
  - GPU (i=0): target = dest[1:0]+1 with direction 01 when not local. A local destination (loopback) is a drop.
  - Spine (i>0): target = 0 with direction 10 when local. A non-local destination is a drop.
- State machine: IDLE, XFER, DROP.
  - IDLE: if arb_enable and req!=0, pick the first requesting index at or after rr_ptr, wrapping modulo 5. Register grant, current_grant, target_sel and direction. Go to XFER, or to DROP when the decode says drop.
  - Grant latency: one cycle from req sampled to grant visible.
  - XFER: beat = tgt_ready[target_sel] (combinational from the registered grant). beat_cnt increments on each beat.
  - XFER release occurs on any of:
    - req[granted] low,
    - arb_enable low,
    - a beat with beat_cnt==MAX_BURST-1.
  - On release: go to IDLE, clear grant, set rr_ptr=(granted+1) mod 5, clear beat_cnt. The next grant earliest one cycle later (one idle bubble per handoff).
  - A stalled target (tgt_ready low) holds the grant indefinitely with no beat counted. Only req drop or arb_enable low releases it.
  - DROP: lasts one cycle with grant asserted as the drop acknowledge and beat=0. drop_count increments and saturates at 255. Then IDLE with rr_ptr advanced past the dropped requester.
- Destination sampling: dest_addr is sampled only at grant time. Changes during XFER are ignored.
- Reset mid-XFER returns to the reset values at the next edge; in-flight beats are abandoned.
- Simultaneous requests: only the round-robin order decides; there is no priority to the GPU.
- dest_addr changing in IDLE without req has no effect.

Decomposition:
- Shared package (leaf_router_pkg):
  - requester index constants (REQ_GPU=0, REQ_SP1..4=1..4),
  - direction encodings (DIR_IDLE/UP/DOWN/DROP),
  - IDLE_GRANT=3'd7,
  - state encodings,
  - dest field positions (GRP_MSB=5, GRP_LSB=2, RTR_MSB=1, RTR_LSB=0).
- One sub-module: rr_pick5. It is combinational, takes req[4:0] and ptr[2:0], and returns a valid flag and index[2:0]. It is reused by the spine-side schedulers.

Test Plan:
- Reset, then GPU req, dest=6'b011101 (group 7, router 1), tgt_ready=5'b11111, held 6 cycles -> next cycle grant=00001, target_sel=2, direction=01, busy=1; 4 beats then release; 1 idle cycle; regrant to GPU.
- req=5'b10110, all dests local 6'b011110, rr_ptr=0 -> grants in order 1,2,4, each for up to 4 beats; current_grant=7 in the bubbles.
- Spine3 req, dest=6'b010010 (non-local) -> one cycle with grant=01000, direction=11, beat=0; drop_count 0->1; rr_ptr=4.
- GPU granted to spine2 with tgt_ready[2]=0 for 10 cycles, then 1 -> no beats and grant held while stalled; 4 beats after release of the stall.
- Mid-XFER arb_enable=0 -> IDLE at the next edge and no new grants while low. Mid-XFER reset=1 -> all outputs at reset values after one edge.
- 300 consecutive drop requests -> drop_count saturates at 255.
